alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Operand-issue and writeback stage wrapped around the 16-bit ALU. It accepts one decoded operation per cycle and reads operands from an internal 8x16 register file, with forwarding. It drives the ALU inputs from a registered EX stage, captures the ALU result and flags, and retires the result into the register file two edges after acceptance. Z and C are held as architectural flags for branch logic.

## Interface
- `NREGS`, 8: register-file depth. Fixed at 8; 3-bit register addresses.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: a decoded operation is presented.
- `in_ready` output 1: stage can accept; equals `!hold`.
- `hold` input 1: freezes the whole stage.
- `in_code` input 3: ALU operation code, passed through unchanged.
- `in_rd`, `in_rs`, `in_rt` input 3 each: destination and source register indices.
- `in_use_imm` input 1: when 1, B = `in_imm` and `in_rt` is ignored.
- `in_imm` input 16: immediate operand.
- `alu_a`, `alu_b` output 16: registered operands to the ALU.
- `alu_code` output 3: registered ALU operation code.
- `alu_out` input 16: ALU result (combinational from `alu_a`/`alu_b`/`alu_code`).
- `alu_carry`, `alu_zero` input 1 each: ALU carry and zero outputs.
- `wb_valid` output 1: the WB stage holds a retiring result.
- `wb_rd` output 3: destination index in WB.
- `wb_data` output 16: result in WB.
- `flag_z`, `flag_c` output 1 each: architectural flags.
- `dbg_addr` input 3: debug read index.
- `dbg_data` output 16: raw register-file read of `dbg_addr`, with no forwarding.

## Operation
- **Accept:** an operation is accepted at a rising edge when `in_valid && in_ready`. There is no other stall source.
- **Register r0:** r0 reads as 0 everywhere. Writes to r0 are dropped, but the operation still retires, asserts `wb_valid`, and updates the flags.
- **Operand select at accept:**
  - A = fwd(`in_rs`).
  - B = `in_imm` when `in_use_imm`, else fwd(`in_rt`).
  - fwd(r) has priority EX-stage result (`alu_out`, if EX valid and EX rd == r != 0), then WB result (`wb_data`, if `wb_valid` and `wb_rd` == r != 0), then the register file.
- **EX stage:** holds the valid bit, rd, and code, and drives `alu_a`, `alu_b`, `alu_code` directly. Contents persist while the EX valid bit is 0 (bubble).
- **WB stage:** captures `alu_out`, `alu_carry`, `alu_zero`, rd, code, and the valid bit at each non-held edge.
- **Retire (edge after WB load, when `wb_valid`):**
  - The register file writes `wb_data` to `wb_rd`, unless `wb_rd` is 0.
  - `flag_z` is loaded from the captured `alu_zero`.
  - `flag_c` is loaded from the captured carry only when WB code = 3'b000 (ADD). Otherwise `flag_c` keeps its value.
- **Bubbles:** a cycle with no accept loads EX valid = 0. This propagates to `wb_valid` = 0, so no write and no flag update.
- **hold = 1 at an edge:**
  - The EX register, WB register, register file, and flags are all unchanged.
  - No accept occurs (`in_ready` = 0).
  - The outputs keep showing the frozen state, so forwarding stays consistent.
- **Arithmetic:** performed entirely by the ALU. This stage does no width conversion; operands and results are 16 bits, wrapping modulo 2^16.

## Timing
- **Reset** (asynchronous assert, released synchronously to `clk` by the system):
  - All register-file entries = 0.
  - EX valid = 0; `alu_a` = `alu_b` = 0; `alu_code` = 0.
  - `wb_valid` = 0; `wb_rd` = 0; `wb_data` = 0.
  - `flag_z` = 0; `flag_c` = 0.
  - `in_ready` follows `hold` combinationally.
- **Latency** for an operation accepted at edge E0:
  - `alu_*` are valid in the cycle after E0.
  - `wb_valid`/`wb_data` are valid in the cycle after E1.
  - The register file and flags update at E2; `dbg_data` reflects the result from the cycle after E2.
- **Throughput:** 1 op/cycle with no hazard stalls. Back-to-back dependents are resolved by forwarding.
- **Simultaneous retire and read:** a retire to register r at edge E coincides with an accept reading r at E. Forwarding from WB supplies the new value; the register-file write and the read never race.
- **Reset mid-operation:** in-flight EX and WB operations are discarded with no write. Register-file contents and flags return to 0.
- **hold:** holding for N edges adds exactly N cycles of latency to every in-flight operation.

## Test plan
- **Reset/idle:** assert `rst_n` = 0 mid-run, then release.
  - Expect `wb_valid` = 0, flags = 0, and `dbg_data` = 0 for all 8 registers.
- **Immediate chain:**
  - Issue ADDI-style ops r1 = r0 + 5 and r2 = r0 + 0xFFFF on consecutive cycles, then ADD r3 = r1 + r2 back-to-back.
  - Expect r3 = 0x0004 and `flag_c` = 1 via EX forwarding.
  - Expect `dbg_data(r3)` = 0x0004 in the cycle after the third retire.
- **WB forwarding:** issue r1 = 7, one bubble, then SUB r4 = r1 − r1.
  - Expect `alu_a` = `alu_b` = 7, r4 = 0, and `flag_z` = 1.
  - Expect `flag_c` to keep the value left by the prior ADD.
- **r0 write:** issue OR r0 = r0 | imm 0x00FF.
  - Expect `wb_valid` = 1, `wb_data` = 0x00FF, `dbg_data(r0)` = 0, and `flag_z` = 0.
- **Hold:** accept an op, then assert `hold` for 3 cycles.
  - Expect `in_ready` = 0 and `wb_valid` and `wb_data` unchanged throughout.
  - Expect the retire to occur exactly 3 edges late with the correct value.
- **Reset mid-flight:** accept r5 = 9, then assert `rst_n` = 0 before E2.
  - Expect `dbg_data(r5)` = 0 and `wb_valid` = 0 after release.

Source files
------------

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_stage
// Purpose  : Operand-issue and writeback stage around an external 16-bit ALU.
//            It accepts one decoded op per cycle and reads operands from an
//            internal 8x16 register file, with EX/WB forwarding. A registered
//            EX stage drives the ALU, and a WB stage captures the result and
//            flags and retires them into the register file and the Z/C flags.
// Ports    : clk, rst_n            - clock, async active-low reset
//            in_valid/in_ready     - op handshake (in_ready = !hold)
//            hold                  - freezes the whole stage
//            in_code/rd/rs/rt      - decoded op fields
//            in_use_imm/in_imm     - immediate B operand select/value
//            alu_a/alu_b/alu_code  - registered ALU inputs (EX stage)
//            alu_out/carry/zero    - ALU results (combinational)
//            wb_valid/wb_rd/wb_data- retiring result in WB
//            flag_z/flag_c         - architectural flags
//            dbg_addr/dbg_data     - raw register-file read port
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_stage #(
  parameter int NREGS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        hold,
  input  logic [2:0]  in_code,
  input  logic [2:0]  in_rd,
  input  logic [2:0]  in_rs,
  input  logic [2:0]  in_rt,
  input  logic        in_use_imm,
  input  logic [15:0] in_imm,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_code,
  input  logic [15:0] alu_out,
  input  logic        alu_carry,
  input  logic        alu_zero,
  output logic        wb_valid,
  output logic [2:0]  wb_rd,
  output logic [15:0] wb_data,
  output logic        flag_z,
  output logic        flag_c,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data
);

  localparam logic [2:0] CODE_ADD = 3'b000;

  logic [15:0] rf [NREGS];

  logic        ex_valid;
  logic [2:0]  ex_rd;

  logic [2:0]  wb_code;
  logic        wb_carry;
  logic        wb_zero;

  logic        accept;
  logic [15:0] op_a;
  logic [15:0] op_b;

  assign in_ready = !hold;
  assign accept   = in_valid && !hold;
  assign dbg_data = rf[dbg_addr];

  // Youngest producer wins: the op now in EX is later in program order than
  // the one in WB, which is later than anything already in the register file.
  // r0 is never written, so falling through to rf[0] yields 0.
  function automatic logic [15:0] fwd(input logic [2:0] r);
    if (ex_valid && (ex_rd == r) && (r != 3'd0)) begin
      return alu_out;
    end else if (wb_valid && (wb_rd == r) && (r != 3'd0)) begin
      return wb_data;
    end else begin
      return rf[r];
    end
  endfunction

  always_comb begin
    op_a = fwd(in_rs);
    op_b = in_use_imm ? in_imm : fwd(in_rt);
  end

  // EX stage: operands persist across bubbles; only the valid bit drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_rd    <= 3'd0;
      alu_code <= 3'd0;
      alu_a    <= 16'd0;
      alu_b    <= 16'd0;
    end else if (!hold) begin
      ex_valid <= accept;
      if (accept) begin
        ex_rd    <= in_rd;
        alu_code <= in_code;
        alu_a    <= op_a;
        alu_b    <= op_b;
      end
    end
  end

  // WB stage: captures the ALU outcome at every non-held edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_rd    <= 3'd0;
      wb_data  <= 16'd0;
      wb_code  <= 3'd0;
      wb_carry <= 1'b0;
      wb_zero  <= 1'b0;
    end else if (!hold) begin
      wb_valid <= ex_valid;
      wb_rd    <= ex_rd;
      wb_data  <= alu_out;
      wb_code  <= alu_code;
      wb_carry <= alu_carry;
      wb_zero  <= alu_zero;
    end
  end

  // Retire: register write (never to r0) and flag update. Carry is only
  // architecturally defined by ADD, so other ops leave flag_c alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        rf[i] <= 16'd0;
      end
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else if (!hold && wb_valid) begin
      if (wb_rd != 3'd0) begin
        rf[wb_rd] <= wb_data;
      end
      flag_z <= wb_zero;
      if (wb_code == CODE_ADD) begin
        flag_c <= wb_carry;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_stage
// Purpose  : Self-checking bench for alu_issue_stage. Supplies a small ALU
//            model, keeps a program-order behavioural model of the stage,
//            compares every cycle, and pins key results with literals.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;

  localparam logic [2:0] ADD = 3'd0;
  localparam logic [2:0] SUB = 3'd1;
  localparam logic [2:0] AND = 3'd2;
  localparam logic [2:0] OR  = 3'd3;
  localparam logic [2:0] XOR = 3'd4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        hold;
  logic [2:0]  in_code, in_rd, in_rs, in_rt;
  logic        in_use_imm;
  logic [15:0] in_imm;
  logic [15:0] alu_a, alu_b;
  logic [2:0]  alu_code;
  logic [15:0] alu_out;
  logic        alu_carry, alu_zero;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic        flag_z, flag_c;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  int n_chk  = 0;
  int n_pass = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  // ALU: returns {carry, zero, result}
  function automatic logic [17:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [2:0] code);
    logic [16:0] s;
    logic [15:0] r;
    logic        c;
    c = 1'b0;
    case (code)
      ADD: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16]; end
      SUB: begin r = a - b; c = (a < b); end
      AND: r = a & b;
      OR:  r = a | b;
      XOR: r = a ^ b;
      default: r = a;
    endcase
    return {c, (r == 16'd0), r};
  endfunction

  assign {alu_carry, alu_zero, alu_out} = alu_f(alu_a, alu_b, alu_code);

  alu_issue_stage #(.NREGS(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .hold(hold), .in_code(in_code), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
    .in_use_imm(in_use_imm), .in_imm(in_imm), .alu_a(alu_a), .alu_b(alu_b),
    .alu_code(alu_code), .alu_out(alu_out), .alu_carry(alu_carry),
    .alu_zero(alu_zero), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .flag_z(flag_z), .flag_c(flag_c), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // ---------------- behavioural model ----------------
  // m_spec: register values in program order (every accepted op applied at
  // once). m_arch: what has actually retired. In-flight ops are tracked by
  // age: m_ex_* one non-held edge after accept, m_wb_* two.
  logic [15:0] m_spec [8];
  logic [15:0] m_arch [8];
  logic        m_fz, m_fc;
  logic        m_ex_v;
  logic [2:0]  m_ex_rd, m_ex_code;
  logic [15:0] m_ex_a, m_ex_b, m_ex_res;
  logic        m_ex_c, m_ex_z;
  logic        m_wb_v;
  logic [2:0]  m_wb_rd, m_wb_code;
  logic [15:0] m_wb_res;
  logic        m_wb_c, m_wb_z;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_spec[i] = 16'd0;
      m_arch[i] = 16'd0;
    end
    m_fz = 1'b0; m_fc = 1'b0;
    m_ex_v = 1'b0; m_ex_rd = 3'd0; m_ex_code = 3'd0;
    m_ex_a = 16'd0; m_ex_b = 16'd0; m_ex_res = 16'd0; m_ex_c = 1'b0; m_ex_z = 1'b0;
    m_wb_v = 1'b0; m_wb_rd = 3'd0; m_wb_code = 3'd0;
    m_wb_res = 16'd0; m_wb_c = 1'b0; m_wb_z = 1'b0;
  endtask

  task automatic model_edge();
    logic [17:0] r;
    if (!rst_n) begin
      model_reset();
    end else if (!hold) begin
      if (m_wb_v) begin
        if (m_wb_rd != 3'd0) m_arch[m_wb_rd] = m_wb_res;
        m_fz = m_wb_z;
        if (m_wb_code == ADD) m_fc = m_wb_c;
      end
      m_wb_v = m_ex_v; m_wb_rd = m_ex_rd; m_wb_code = m_ex_code;
      m_wb_res = m_ex_res; m_wb_c = m_ex_c; m_wb_z = m_ex_z;
      m_ex_v = in_valid;
      if (in_valid) begin
        m_ex_a    = m_spec[in_rs];
        m_ex_b    = in_use_imm ? in_imm : m_spec[in_rt];
        m_ex_rd   = in_rd;
        m_ex_code = in_code;
        r = alu_f(m_ex_a, m_ex_b, in_code);
        {m_ex_c, m_ex_z, m_ex_res} = r;
        if (in_rd != 3'd0) m_spec[in_rd] = m_ex_res;
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", {15'd0, in_ready}, {15'd0, !hold});
      chk("alu_a", alu_a, m_ex_a);
      chk("alu_b", alu_b, m_ex_b);
      chk("alu_code", {13'd0, alu_code}, {13'd0, m_ex_code});
      chk("wb_valid", {15'd0, wb_valid}, {15'd0, m_wb_v});
      if (m_wb_v) begin
        chk("wb_rd", {13'd0, wb_rd}, {13'd0, m_wb_rd});
        chk("wb_data", wb_data, m_wb_res);
      end
      chk("flag_z", {15'd0, flag_z}, {15'd0, m_fz});
      chk("flag_c", {15'd0, flag_c}, {15'd0, m_fc});
      chk("dbg_data", dbg_data, m_arch[dbg_addr]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic op(input logic [2:0] code, input logic [2:0] rd, input logic [2:0] rs,
                    input logic [2:0] rt, input logic ui, input logic [15:0] imm);
    in_valid = 1'b1; in_code = code; in_rd = rd; in_rs = rs; in_rt = rt;
    in_use_imm = ui; in_imm = imm;
    tick();
    in_valid = 1'b0;
  endtask

  // Literal check, taken between the edge and the compare process.
  task automatic lit(input string name, input logic [15:0] act, input logic [15:0] exp);
    #1;
    chk(name, act, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; hold = 1'b0; in_valid = 1'b0; in_code = 3'd0; in_rd = 3'd0;
    in_rs = 3'd0; in_rt = 3'd0; in_use_imm = 1'b0; in_imm = 16'd0; dbg_addr = 3'd0;
    model_reset();
    chk_en = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Immediate chain with EX forwarding into a back-to-back ADD.
    dbg_addr = 3'd3;
    op(ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'd5);
    op(ADD, 3'd2, 3'd0, 3'd0, 1'b1, 16'hFFFF);
    op(ADD, 3'd3, 3'd1, 3'd2, 1'b0, 16'd0);
    lit("chain_alu_a", alu_a, 16'd5);
    lit("chain_alu_b", alu_b, 16'hFFFF);
    tick();
    tick();
    lit("chain_r3", dbg_data, 16'h0004);
    lit("chain_flag_c", {15'd0, flag_c}, 16'd1);

    // Dependent mix: logic ops and SUB chained through forwarding.
    op(XOR, 3'd4, 3'd3, 3'd0, 1'b1, 16'h00F0);
    op(AND, 3'd5, 3'd4, 3'd1, 1'b0, 16'd0);
    op(SUB, 3'd6, 3'd4, 3'd5, 1'b0, 16'd0);
    op(OR,  3'd7, 3'd6, 3'd3, 1'b0, 16'd0);
    repeat (3) tick();
    dbg_addr = 3'd7;
    lit("mix_r7", dbg_data, 16'h00F4);

    // Reset while registers hold data: everything returns to zero.
    rst_n = 1'b0;
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();
    lit("idle_wb_valid", {15'd0, wb_valid}, 16'd0);
    lit("idle_flags", {14'd0, flag_z, flag_c}, 16'd0);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      lit("idle_reg", dbg_data, 16'd0);
    end

    // WB forwarding across one bubble.
    op(ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'd7);
    tick();
    op(SUB, 3'd4, 3'd1, 3'd1, 1'b0, 16'd0);
    lit("wbf_alu_a", alu_a, 16'd7);
    lit("wbf_alu_b", alu_b, 16'd7);
    dbg_addr = 3'd4;
    tick();
    tick();
    lit("wbf_flag_z", {15'd0, flag_z}, 16'd1);
    lit("wbf_flag_c", {15'd0, flag_c}, 16'd0);
    lit("wbf_r4", dbg_data, 16'd0);

    // Write to r0 still retires and updates flags.
    dbg_addr = 3'd0;
    op(OR, 3'd0, 3'd0, 3'd0, 1'b1, 16'h00FF);
    tick();
    lit("r0_wb_valid", {15'd0, wb_valid}, 16'd1);
    lit("r0_wb_data", wb_data, 16'h00FF);
    tick();
    lit("r0_reg", dbg_data, 16'd0);
    lit("r0_flag_z", {15'd0, flag_z}, 16'd0);

    // Hold for three edges with an op in EX; offered ops must be ignored.
    dbg_addr = 3'd6;
    op(ADD, 3'd6, 3'd0, 3'd0, 1'b1, 16'h1234);
    hold = 1'b1;
    in_valid = 1'b1; in_rd = 3'd2; in_use_imm = 1'b1; in_imm = 16'hBEEF;
    repeat (3) tick();
    lit("hold_in_ready", {15'd0, in_ready}, 16'd0);
    lit("hold_wb_valid", {15'd0, wb_valid}, 16'd0);
    in_valid = 1'b0;
    hold = 1'b0;
    tick();
    lit("hold_wb_data", wb_data, 16'h1234);
    lit("hold_r6_early", dbg_data, 16'd0);
    tick();
    lit("hold_r6", dbg_data, 16'h1234);

    // Reset before the retire edge discards the in-flight op.
    dbg_addr = 3'd5;
    op(ADD, 3'd5, 3'd0, 3'd0, 1'b1, 16'd9);
    tick();
    rst_n = 1'b0;
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();
    lit("rmf_r5", dbg_data, 16'd0);
    lit("rmf_wb_valid", {15'd0, wb_valid}, 16'd0);
    tick();
    tick();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
